cfunc_sized_fifo: RTL and testbench

Synchronous single-clock FIFO whose storage depth is any integer ≥ 2 (not restricted to powers of two). All internal widths (pointers, occupancy counter) are derived at elaboration by constant function calls on the parameters. It sits between producer and consumer blocks in the constant-function regression designs, and exercises constant functions in declarations together with real sequential behaviour.

---
 rtl/cfunc_sized_fifo_if.sv | 34 +++
 rtl/cfunc_sized_fifo.sv | 90 +++++++++
 tb/tb_cfunc_sized_fifo.sv | 181 ++++++++++++++++++
 3 files changed

// File: rtl/cfunc_sized_fifo_if.sv
// Producer/consumer side bundle of the arbitrary-depth FIFO.
// The count width matches the FIFO's own derivation for every legal DEPTH (>= 2).
interface cfunc_sized_fifo_if #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 5
) ();
    localparam int unsigned CW = $clog2(DEPTH + 1);

    logic             push;
    logic [WIDTH-1:0] wr_data;
    logic             pop;
    logic             clr_err;
    logic [WIDTH-1:0] rd_data;
    logic             rd_valid;
    logic             full;
    logic             empty;
    logic             almost_full;
    logic             almost_empty;
    logic [CW-1:0]    count;
    logic             overflow;
    logic             underflow;

    modport master (
        output push, wr_data, pop, clr_err,
        input  rd_data, rd_valid, full, empty, almost_full, almost_empty,
               count, overflow, underflow
    );

    modport slave (
        input  push, wr_data, pop, clr_err,
        output rd_data, rd_valid, full, empty, almost_full, almost_empty,
               count, overflow, underflow
    );
endinterface

// File: rtl/cfunc_sized_fifo.sv
// Single-clock FIFO of any depth >= 2; pointer and counter widths come from a
// constant function evaluated at elaboration.
module cfunc_sized_fifo #(
    parameter int unsigned WIDTH    = 8,
    parameter int unsigned DEPTH    = 5,
    parameter int unsigned AF_LEVEL = DEPTH - 1,
    parameter int unsigned AE_LEVEL = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    cfunc_sized_fifo_if.slave     bus
);
    // Ceiling log2 with clog2(1) = 1 so a width is never zero.
    function automatic int unsigned clog2(input int unsigned v);
        int unsigned r;
        r = 0;
        for (int i = 0; i < 32; i++) begin
            if ((64'(1) << i) < 64'(v)) r = 32'(i) + 32'd1;
        end
        if (r == 0) r = 1;
        return r;
    endfunction

    localparam int unsigned AW = clog2(DEPTH);
    localparam int unsigned CW = clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wp;
    logic [AW-1:0]    rp;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] rd_data_q;
    logic             rd_valid_q;
    logic             overflow_q;
    logic             underflow_q;

    logic do_push;
    logic do_pop;

    // Wrap at DEPTH-1 rather than at a power of two.
    function automatic logic [AW-1:0] ptr_next(input logic [AW-1:0] p);
        return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
    endfunction

    // A push into a full FIFO is still taken when a pop frees a slot this cycle.
    always_comb begin
        do_pop  = bus.pop && (cnt != '0);
        do_push = bus.push && ((cnt != CW'(DEPTH)) || do_pop);
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wp] <= bus.wr_data;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wp          <= '0;
            rp          <= '0;
            cnt         <= '0;
            rd_data_q   <= '0;
            rd_valid_q  <= 1'b0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            rd_valid_q <= do_pop;
            if (do_push) wp <= ptr_next(wp);
            if (do_pop) begin
                rd_data_q <= mem[rp];
                rp        <= ptr_next(rp);
            end
            if (do_push && !do_pop)      cnt <= cnt + CW'(1);
            else if (do_pop && !do_push) cnt <= cnt - CW'(1);

            // A new error in the same cycle as clr_err keeps the flag set.
            if (bus.push && !do_push) overflow_q <= 1'b1;
            else if (bus.clr_err)     overflow_q <= 1'b0;
            if (bus.pop && !do_pop)   underflow_q <= 1'b1;
            else if (bus.clr_err)     underflow_q <= 1'b0;
        end
    end

    assign bus.rd_data      = rd_data_q;
    assign bus.rd_valid     = rd_valid_q;
    assign bus.count        = cnt;
    assign bus.full         = (cnt == CW'(DEPTH));
    assign bus.empty        = (cnt == '0);
    assign bus.almost_full  = (32'(cnt) >= AF_LEVEL);
    assign bus.almost_empty = (32'(cnt) <= AE_LEVEL);
    assign bus.overflow     = overflow_q;
    assign bus.underflow    = underflow_q;
endmodule

// File: tb/tb_cfunc_sized_fifo.sv
// Directed bench for cfunc_sized_fifo: a DEPTH=5 instance for the main
// behaviour and a DEPTH=8 instance for the derived-width case.
module tb_cfunc_sized_fifo;
    logic clk;
    logic rst_n;

    cfunc_sized_fifo_if #(.WIDTH(8), .DEPTH(5)) bus  ();
    cfunc_sized_fifo_if #(.WIDTH(8), .DEPTH(8)) bus8 ();

    cfunc_sized_fifo #(.WIDTH(8), .DEPTH(5)) dut  (.clk(clk), .rst_n(rst_n), .bus(bus));
    cfunc_sized_fifo #(.WIDTH(8), .DEPTH(8)) dut8 (.clk(clk), .rst_n(rst_n), .bus(bus8));

    int n_chk;
    int n_pass;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    // Advance one edge and settle just after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.push = 1'b0; bus.pop = 1'b0; bus.clr_err = 1'b0; bus.wr_data = '0;
    endtask

    task automatic do_push(input logic [7:0] d);
        bus.push = 1'b1; bus.wr_data = d;
        tick();
        idle();
    endtask

    task automatic do_pop_chk(input string tag, input logic [7:0] exp);
        bus.pop = 1'b1;
        tick();
        idle();
        check({tag, "_valid"}, 32'(bus.rd_valid), 32'd1);
        check({tag, "_data"}, 32'(bus.rd_data), 32'(exp));
    endtask

    task automatic do_clr();
        bus.clr_err = 1'b1;
        tick();
        idle();
    endtask

    initial begin
        n_chk = 0; n_pass = 0;
        idle();
        bus8.push = 1'b0; bus8.pop = 1'b0; bus8.clr_err = 1'b0; bus8.wr_data = '0;
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        #1;
        check("rst_empty",  32'(bus.empty), 32'd1);
        check("rst_full",   32'(bus.full), 32'd0);
        check("rst_count",  32'(bus.count), 32'd0);
        check("rst_valid",  32'(bus.rd_valid), 32'd0);
        check("rst_data",   32'(bus.rd_data), 32'h00);
        check("rst_ovf",    32'(bus.overflow), 32'd0);
        check("rst_udf",    32'(bus.underflow), 32'd0);
        check("rst_ae",     32'(bus.almost_empty), 32'd1);
        check("rst_af",     32'(bus.almost_full), 32'd0);
        tick(); tick();
        rst_n = 1'b1;

        // Fill to DEPTH, watching thresholds at every level.
        for (int i = 0; i < 5; i++) begin
            do_push(8'(8'h11 * (i + 1)));
            check("fill_count", 32'(bus.count), 32'(i + 1));
            check("fill_af",    32'(bus.almost_full), (i + 1 >= 4) ? 32'd1 : 32'd0);
            check("fill_ae",    32'(bus.almost_empty), (i + 1 <= 1) ? 32'd1 : 32'd0);
        end
        check("fill_full", 32'(bus.full), 32'd1);
        do_push(8'h66);
        check("ovf_flag",  32'(bus.overflow), 32'd1);
        check("ovf_count", 32'(bus.count), 32'd5);
        for (int i = 0; i < 5; i++) do_pop_chk("drain", 8'(8'h11 * (i + 1)));
        check("drain_empty", 32'(bus.empty), 32'd1);
        tick();
        check("idle_valid", 32'(bus.rd_valid), 32'd0);
        check("idle_hold",  32'(bus.rd_data), 32'h55);
        do_clr();
        check("ovf_clr", 32'(bus.overflow), 32'd0);

        // Four rounds of push 3 / pop 3 cross the 4 -> 0 wrap repeatedly.
        for (int r = 0; r < 4; r++) begin
            for (int k = 0; k < 3; k++) do_push(8'(8'hA0 + r * 3 + k));
            for (int k = 0; k < 3; k++) do_pop_chk("wrap", 8'(8'hA0 + r * 3 + k));
        end
        check("wrap_wp", 32'(dut.wp), 32'd2);
        check("wrap_rp", 32'(dut.rp), 32'd2);
        check("wrap_empty", 32'(bus.empty), 32'd1);

        // Push and pop together on a full FIFO.
        for (int i = 0; i < 5; i++) do_push(8'(8'hB1 + i));
        bus.push = 1'b1; bus.pop = 1'b1; bus.wr_data = 8'hB6;
        tick();
        idle();
        check("pp_full_count", 32'(bus.count), 32'd5);
        check("pp_full_valid", 32'(bus.rd_valid), 32'd1);
        check("pp_full_data",  32'(bus.rd_data), 32'hB1);
        check("pp_full_ovf",   32'(bus.overflow), 32'd0);
        for (int i = 0; i < 5; i++) do_pop_chk("pp_drain", 8'(8'hB2 + i));
        check("pp_drain_empty", 32'(bus.empty), 32'd1);

        // Push and pop together on an empty FIFO: only the push lands.
        bus.push = 1'b1; bus.pop = 1'b1; bus.wr_data = 8'hC1;
        tick();
        idle();
        check("pp_empty_count", 32'(bus.count), 32'd1);
        check("pp_empty_udf",   32'(bus.underflow), 32'd1);
        check("pp_empty_valid", 32'(bus.rd_valid), 32'd0);
        check("pp_empty_hold",  32'(bus.rd_data), 32'hB6);
        do_pop_chk("pp_empty_pop", 8'hC1);
        do_clr();
        check("udf_clr", 32'(bus.underflow), 32'd0);
        bus.pop = 1'b1;
        tick();
        idle();
        check("udf_set",   32'(bus.underflow), 32'd1);
        check("udf_count", 32'(bus.count), 32'd0);
        do_clr();
        check("udf_clr2", 32'(bus.underflow), 32'd0);
        bus.pop = 1'b1; bus.clr_err = 1'b1;
        tick();
        idle();
        check("udf_set_wins", 32'(bus.underflow), 32'd1);
        do_clr();

        // Asynchronous reset with data in flight.
        for (int i = 0; i < 4; i++) do_push(8'(8'hD0 + i));
        bus.pop = 1'b1;
        tick();
        idle();
        check("pre_rst_count", 32'(bus.count), 32'd3);
        check("pre_rst_valid", 32'(bus.rd_valid), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("mid_rst_count", 32'(bus.count), 32'd0);
        check("mid_rst_empty", 32'(bus.empty), 32'd1);
        check("mid_rst_valid", 32'(bus.rd_valid), 32'd0);
        tick();
        rst_n = 1'b1;
        do_push(8'hE1);
        check("post_rst_count", 32'(bus.count), 32'd1);
        do_pop_chk("post_rst_pop", 8'hE1);

        // DEPTH=8: count must reach 8, needing a 4-bit counter and 3-bit pointers.
        for (int i = 0; i < 8; i++) begin
            bus8.push = 1'b1; bus8.wr_data = 8'(i + 1);
            tick();
            bus8.push = 1'b0;
            if (i == 6) check("d8_count7_full", 32'(bus8.full), 32'd0);
        end
        check("d8_count", 32'(bus8.count), 32'd8);
        check("d8_full",  32'(bus8.full), 32'd1);
        bus8.push = 1'b1; bus8.wr_data = 8'h99;
        tick();
        bus8.push = 1'b0;
        check("d8_ovf", 32'(bus8.overflow), 32'd1);
        for (int i = 0; i < 8; i++) begin
            bus8.pop = 1'b1;
            tick();
            bus8.pop = 1'b0;
            check("d8_data", 32'(bus8.rd_data), 32'(i + 1));
        end
        check("d8_empty", 32'(bus8.empty), 32'd1);
        check("d8_wp", 32'(dut8.wp), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
